// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, round constants, controller
// state encoding and the GF(2^8) helpers behind the S-box.
// Used by the key schedule step, the MixColumns block and the round
// controller.
package aes_pkg;

    localparam int AES_NR = 10;

    // Entry 0 is unused; rounds are numbered from 1.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        return (rnd <= 4'd10) ? RCON[rnd] : 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed rather than tabulated: multiplicative inverse as
    // x^254 (0 maps to 0 naturally), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule, purely combinational.
//   rk      : current round key (w0..w3, w0 in bits [127:96])
//   rcon    : round constant for this step
//   rk_next : next round key
module aes_key_step (
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);
    import aes_pkg::*;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk;

    // RotWord moves the top byte of w3 to the bottom before SubWord.
    assign t = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns over the full 128-bit state, combinational.
//   in_state  : state, column-major, column 0 in bits [127:96]
//   out_state : mixed state, same byte order
module mix_columns (
    input  logic [127:0] in_state,
    output logic [127:0] out_state
);
    import aes_pkg::*;

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = in_state[127-32*c -: 32];
        assign out_state[127-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock with the
// key schedule expanded on the fly.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : block input handshake (in_block, in_key)
//   abort               : synchronous abandon of the current operation
//   out_valid/out_ready : ciphertext handshake (out_block)
//   busy                : high while a block is in flight or held
//   round_o             : round counter, for debug
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a block; in_ready high from the edge after entry
// ROUND | one AES round per edge, round_q = round about to execute
// DONE  | ciphertext held on out_block until out_ready or abort
module aes128_round_ctrl
    import aes_pkg::*;
#(
    parameter int ROUNDS = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic [127:0] in_key,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic [3:0]   round_o
);

    localparam logic [3:0] LAST = 4'(ROUNDS);

    state_t       fsm_q;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [3:0]   round_q;

    logic [127:0] sub;
    logic [127:0] shr;
    logic [127:0] mix;
    logic [127:0] rk_next;
    logic         last;

    // Byte n of the state is s(n%4, n/4); ShiftRows takes s(r, c+r).
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = r + 4*c;
            localparam int SRC = r + 4*((c + r) % 4);
            assign sub[127-8*DST -: 8] = sbox(state_q[127-8*DST -: 8]);
            assign shr[127-8*DST -: 8] = sub[127-8*SRC -: 8];
        end
    end

    mix_columns u_mix (
        .in_state  (shr),
        .out_state (mix)
    );

    aes_key_step u_key_step (
        .rk      (rk_q),
        .rcon    (rcon_of(round_q)),
        .rk_next (rk_next)
    );

    assign last = (round_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            rk_q      <= '0;
            round_q   <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_ready && in_valid && !abort) begin
                        state_q  <= in_block ^ in_key;
                        rk_q     <= in_key;
                        round_q  <= 4'd1;
                        fsm_q    <= ROUND;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ROUND: begin
                    if (abort) begin
                        fsm_q    <= IDLE;
                        round_q  <= '0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        state_q <= (last ? shr : mix) ^ rk_next;
                        rk_q    <= rk_next;
                        if (round_q != 4'hf) round_q <= round_q + 4'd1;
                        if (last) begin
                            fsm_q     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // A transfer coinciding with abort still ends in IDLE.
                    if (abort || out_ready) begin
                        fsm_q     <= IDLE;
                        out_valid <= 1'b0;
                        round_q   <= '0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    round_q   <= '0;
                end
            endcase
        end
    end

    // Intermediate round values never leak onto the output bus.
    assign out_block = out_valid ? state_q : '0;
    assign round_o   = round_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
module tb_aes128_round_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_block = '0;
    logic [127:0] in_key = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_block;
    logic [3:0]   round_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes128_round_ctrl #(.ROUNDS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_key    (in_key),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .busy      (busy),
        .round_o   (round_o)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbt [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            if (b[i]) p = p ^ a;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, x, y, c, s;
        c = 8'h63;
        for (int xi = 0; xi < 256; xi++) begin
            x = 8'(xi);
            inv = 8'h00;
            for (int yi = 1; yi < 256; yi++) begin
                y = 8'(yi);
                if (x != 0 && gmul(x, y) == 8'h01) inv = y;
            end
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbt[xi] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] k [16];
        logic [7:0] tw [4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int n = 0; n < 16; n++) begin
            k[n] = key[127-8*n -: 8];
            s[n] = pt[127-8*n -: 8] ^ k[n];
        end
        rc = 8'h01;
        for (int r = 1; r <= nr; r++) begin
            tw[0] = sbt[k[13]] ^ rc;
            tw[1] = sbt[k[14]];
            tw[2] = sbt[k[15]];
            tw[3] = sbt[k[12]];
            for (int i = 0; i < 4; i++) k[i] = k[i] ^ tw[i];
            for (int c = 1; c < 4; c++)
                for (int i = 0; i < 4; i++) k[4*c+i] = k[4*c+i] ^ k[4*(c-1)+i];
            rc = gmul(rc, 8'h02);
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    t[row+4*c] = sbt[s[row + 4*((c+row)%4)]];
            if (r != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = t[n] ^ k[n];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        string        name;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        bit           has_t1;
        logic [127:0] t1;
    } vec_t;

    vec_t vecs[$];
    vec_t app_b, app_c;

    task automatic run_vec(input vec_t v, input int hold);
        int n;
        int cyc;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({v.name, " in_ready before accept"}, in_ready, 1);
        in_block = v.pt;
        in_key   = v.key;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_block = ~v.pt;
        in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk({v.name, " round_o after accept"}, round_o, 1);
        chk({v.name, " busy after accept"}, busy, 1);
        chk({v.name, " in_ready after accept"}, in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1 && v.has_t1) chk({v.name, " state after round 1"}, dut.state_q, v.t1);
        end
        chk({v.name, " latency"}, 128'(cyc), 10);
        chk({v.name, " ciphertext"}, out_block, v.ct);
        chk({v.name, " round_o in DONE"}, round_o, 11);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({v.name, " held out_valid"}, out_valid, 1);
            chk({v.name, " held out_block"}, out_block, v.ct);
            chk({v.name, " held in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({v.name, " out_valid after handshake"}, out_valid, 0);
        chk({v.name, " in_ready after handshake"}, in_ready, 1);
        chk({v.name, " busy after handshake"}, busy, 0);
        chk({v.name, " round_o after handshake"}, round_o, 0);
    endtask

    initial begin
        int n;
        bit seen;
        int cyc, accs, outs;
        int acc_t [2];
        logic [127:0] exp_ct [2];
        logic [127:0] blk [2];
        bit acc;
        vec_t v;

        build_sbox();

        app_b = '{"appB", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32,
                  1'b1, 128'ha49c7ff2689f352b6b5bea43026a5049};
        app_c = '{"appC1", 128'h000102030405060708090a0b0c0d0e0f,
                  128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  1'b0, 128'h0};
        vecs.push_back(app_b);
        vecs.push_back(app_c);
        for (int i = 0; i < 4; i++) begin
            v.name   = $sformatf("rand%0d", i);
            v.key    = {$urandom(), $urandom(), $urandom(), $urandom()};
            v.pt     = {$urandom(), $urandom(), $urandom(), $urandom()};
            v.ct     = aes_ref(v.pt, v.key, 10);
            v.has_t1 = 1'b0;
            v.t1     = '0;
            vecs.push_back(v);
        end

        // reset state
        #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset out_block", out_block, 0);
        chk("reset round_o", round_o, 0);
        #21;
        rst_n = 1'b1;
        chk("in_ready before first edge", in_ready, 0);
        @(posedge clk); #1;
        chk("in_ready after first edge", in_ready, 1);

        // table-driven vectors with random consumer delay
        foreach (vecs[i]) run_vec(vecs[i], $urandom_range(0, 3));

        // backpressure, then immediate reload
        run_vec(app_b, 20);
        run_vec(app_c, 0);

        // abort during round 5
        in_block = app_c.pt; in_key = app_c.key; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (round_o != 4'd5 && n < 20) begin @(posedge clk); #1; n++; end
        chk("abort: reached round 5", round_o, 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort: round_o", round_o, 0);
        chk("abort: busy", busy, 0);
        chk("abort: in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort: out_valid never asserted", seen, 0);
        run_vec(app_b, 0);

        // reset pulse during round 7
        in_block = app_b.pt; in_key = app_b.key; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (round_o != 4'd7 && n < 20) begin @(posedge clk); #1; n++; end
        chk("rst pulse: reached round 7", round_o, 7);
        #1 rst_n = 1'b0;
        #1;
        chk("rst pulse: in_ready", in_ready, 0);
        chk("rst pulse: out_valid", out_valid, 0);
        chk("rst pulse: busy", busy, 0);
        chk("rst pulse: round_o", round_o, 0);
        chk("rst pulse: out_block", out_block, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst pulse: in_ready after release", in_ready, 1);
        run_vec(app_c, 0);

        // in_valid with abort in IDLE is never accepted
        in_block = app_b.pt; in_key = app_b.key; in_valid = 1'b1; abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle abort: busy", busy, 0);
            chk("idle abort: round_o", round_o, 0);
        end
        abort = 1'b0;

        // back-to-back with out_ready tied high
        blk[0] = app_b.pt; exp_ct[0] = app_b.ct;
        blk[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_ct[1] = aes_ref(blk[1], app_b.key, 10);
        out_ready = 1'b1;
        in_block = blk[0];
        accs = 0; outs = 0; cyc = 0;
        acc_t[0] = 0; acc_t[1] = 0;
        while (outs < 2 && cyc < 60) begin
            acc = in_ready && in_valid && !abort;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (accs < 2) acc_t[accs] = cyc;
                accs++;
                if (accs == 1) in_block = blk[1];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (outs < 2) chk($sformatf("b2b ciphertext %0d", outs), out_block, exp_ct[outs]);
                outs++;
            end
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("b2b outputs seen", 128'(outs), 2);
        chk("b2b accepts", 128'(accs), 2);
        chk("b2b accept spacing", 128'(acc_t[1] - acc_t[0]), 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
Iterative AES-128 encryption controller. It sequences the existing combinational round datapath (sub-bytes, shift-rows, mix_columns, add-round-key) at one round per clock, and expands the key on the fly. The block sits between the host-side block interface and the round logic, and owns the state register, round-key register, round counter and the valid/ready handshakes on both sides.

Parameters:
ROUNDS, 10, number of rounds executed; legal values 1..10; 10 = standard AES-128; smaller values are for reduced-round debug only. The last round always omits MixColumns.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  plaintext and key presented
in_ready  output  1  controller can accept a block
in_block  input  128  plaintext; bits[127:120] = s(0,0); column-major; column 0 = bits[127:96]
in_key  input  128  cipher key, same byte order as in_block
abort  input  1  synchronous abandon of the current operation
out_valid  output  1  ciphertext available
out_ready  input  1  consumer accepts ciphertext
out_block  output  128  ciphertext, same byte order as in_block
busy  output  1  high in ROUND and DONE
round_o  output  4  current round counter (debug)

Behaviour:
- Reset (rst_n low, asynchronous): FSM = IDLE; state_q = 0; rk_q = 0; round_q = 0; in_ready = 0 while rst_n is low, 1 from the first edge after release; out_valid = 0; busy = 0; out_block = 0. Reset asserted mid-operation discards all work immediately.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && !abort: state_q <= in_block ^ in_key; rk_q <= in_key; round_q <= 1; go to ROUND.
  - in_valid with abort in the same cycle: abort wins, nothing is accepted, stay in IDLE.
- ROUND (one edge per round):
  - rk_next = key_step(rk_q, RCON[round_q]).
  - If round_q < ROUNDS: state_q <= MixColumns(ShiftRows(SubBytes(state_q))) ^ rk_next.
  - If round_q == ROUNDS: state_q <= ShiftRows(SubBytes(state_q)) ^ rk_next; go to DONE.
  - rk_q <= rk_next; round_q <= round_q + 1, saturating; it does not wrap.
  - in_ready = 0.
- DONE:
  - out_valid = 1; out_block = state_q, held stable until the handshake.
  - On out_ready: go to IDLE and clear out_valid. in_ready rises in the following cycle (no same-cycle reload).
  - out_ready low holds DONE indefinitely.
- abort in ROUND or DONE: next edge goes to IDLE, clears out_valid and round_q, and produces no output. out_valid && out_ready && abort in the same cycle: the transfer counts as completed, and the result is IDLE in either case.
- Latency: accept edge T0, round edges T1..T(ROUNDS); out_valid is high after edge T(ROUNDS). That is 10 cycles from accept for ROUNDS=10. Throughput is one block per ROUNDS+2 cycles with out_ready held high.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- key_step(w0..w3):
  - t = SubWord(RotWord(w3)) ^ {RCON,00,00,00}
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- in_block and in_key are sampled only on the accept edge; later changes are ignored.
- round_o = round_q: 0 in IDLE, ROUNDS+1 in DONE.

Decomposition:
- Shared package aes_pkg holds:
  - AES_NR = 10 and the RCON array
  - FSM state encoding (IDLE=2'd0, ROUND=2'd1, DONE=2'd2)
  - the S-box function, used by both the datapath and key_step.
- Sub-module aes_key_step (128-bit rk in, 8-bit rcon in, 128-bit rk out), purely combinational.
- The controller instantiates the existing mix_columns (in_state/out_state) unchanged; SubBytes and ShiftRows are combinational logic within it.

Test Plan:
- FIPS-197 App. B, ROUNDS=10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_valid exactly 10 cycles after accept, out_block 3925841d02dc09fbdc118597196a0b32; state_q after T1 = a49c7ff2689f352b6b5bea43026a5049.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure: out_ready held low 20 cycles -> out_valid stays 1, out_block stable, in_ready 0; release -> IDLE, next block accepted 1 cycle later.
- Abort during round 5 -> IDLE on next edge, out_valid never asserts; the following App. B block still yields 3925841d...0b32.
- Reset pulse (rst_n low 3 ns, between edges) during round 7 -> all outputs 0 immediately; after release, in_ready=1 and the App. C.1 vector passes.
- Back-to-back: two blocks with out_ready tied high -> accepts spaced 12 cycles apart, both ciphertexts correct, in_valid+abort in IDLE never accepted.
